// File: rtl/lutram_request_ctrl.sv
// lutram_request_ctrl
//   Request front-end for single_port_lutram. Accepts read and byte-masked
//   write requests over a valid/ready handshake, drives every LUTRAM access
//   port, and registers the LUTRAM's combinational read data into a one-entry
//   response stage with its own valid/ready handshake. After every reset the
//   block sweeps all sets to zero before it accepts a request.
//
//   Optional feature (compile-time macro LUTRAM_REQUEST_CTRL_WRITE_ACK_EN):
//   accepted writes also return a response. The response carries the merged
//   entry: new data on lanes whose mask bit is set, the pre-write contents on
//   the other lanes.
//
// Ports
//   clk_in, reset_in          clock, synchronous active-high reset
//   request_*                 upstream request channel (valid/ready, write,
//                             addr, byte mask, data)
//   response_*                downstream response channel (valid/ready, data)
//   init_done_out             zero sweep complete
//   lutram_*_out              to single_port_lutram access ports
//   lutram_read_entry_in      LUTRAM combinational read data

`ifndef BYTE_LEN_IN_BITS
`define BYTE_LEN_IN_BITS 8
`endif

module lutram_request_ctrl #(
    parameter int SINGLE_ENTRY_SIZE_IN_BITS = 64,
    parameter int NUM_SET                   = 64,
    parameter int SET_PTR_WIDTH_IN_BITS     = $clog2(NUM_SET),
    parameter int WRITE_MASK_LEN            = SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,

    input  logic                                 request_valid_in,
    output logic                                 request_ready_out,
    input  logic                                 request_write_in,
    input  logic [SET_PTR_WIDTH_IN_BITS-1:0]     request_addr_in,
    input  logic [WRITE_MASK_LEN-1:0]            request_mask_in,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] request_data_in,

    output logic                                 response_valid_out,
    input  logic                                 response_ready_in,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_data_out,

    output logic                                 init_done_out,

    output logic                                 lutram_access_en_out,
    output logic [WRITE_MASK_LEN-1:0]            lutram_write_en_out,
    output logic [SET_PTR_WIDTH_IN_BITS-1:0]     lutram_set_addr_out,
    output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_write_entry_out,
    input  logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] lutram_read_entry_in
);

    localparam int BYTE_BITS = `BYTE_LEN_IN_BITS;
    localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] LAST_SET = SET_PTR_WIDTH_IN_BITS'(NUM_SET - 1);

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    state_t                               state;
    logic [SET_PTR_WIDTH_IN_BITS-1:0]     init_count;
    logic                                 request_accept;
    logic                                 response_load;
    logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0] response_next;

    // The reset term keeps a request presented in the reset cycle from being
    // handshaken or reaching the LUTRAM while the state register is reloaded.
    assign request_ready_out = !reset_in && (state == IDLE) &&
                               (!response_valid_out || response_ready_in);
    assign request_accept    = request_valid_in && request_ready_out;

`ifdef LUTRAM_REQUEST_CTRL_WRITE_ACK_EN
    // Every accepted request produces a response; a write returns the entry
    // as it will read after the write lands.
    assign response_load = request_accept;

    always_comb begin
        response_next = lutram_read_entry_in;
        if (request_write_in) begin
            for (int i = 0; i < WRITE_MASK_LEN; i++) begin
                if (request_mask_in[i]) begin
                    response_next[i*BYTE_BITS +: BYTE_BITS] = request_data_in[i*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end
`else
    assign response_load = request_accept && !request_write_in;
    assign response_next = lutram_read_entry_in;
`endif

    // LUTRAM port drive: the zero sweep owns the ports during INIT, the
    // request channel owns them in IDLE.
    always_comb begin
        // NOTE: every output gets a default before the branches so no path
        // leaves one unassigned and infers a latch.
        lutram_access_en_out   = 1'b0;
        lutram_write_en_out    = '0;
        lutram_set_addr_out    = request_addr_in;
        lutram_write_entry_out = request_data_in;
        if (!reset_in) begin
            if (state == INIT) begin
                lutram_access_en_out   = 1'b1;
                lutram_write_en_out    = '1;
                lutram_set_addr_out    = init_count;
                lutram_write_entry_out = '0;
            end else begin
                lutram_access_en_out = request_accept;
                if (request_accept && request_write_in) begin
                    lutram_write_en_out = request_mask_in;
                end
            end
        end
    end

    // NOTE: the LUTRAM array itself has no reset port; its contents are
    // cleared by the sweep below, one set per cycle, after each reset.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset_in) begin
            state              <= INIT;
            init_count         <= '0;
            init_done_out      <= 1'b0;
            response_valid_out <= 1'b0;
            response_data_out  <= '0;
        end else begin
            case (state)
                INIT: begin
                    // The counter parks on the last set instead of wrapping.
                    if (init_count == LAST_SET) begin
                        state         <= IDLE;
                        init_done_out <= 1'b1;
                    end else begin
                        init_count <= init_count + SET_PTR_WIDTH_IN_BITS'(1);
                    end
                end
                IDLE: begin
                    // A new load wins over a drain in the same cycle, which
                    // keeps valid high across back-to-back reads.
                    if (response_load) begin
                        response_valid_out <= 1'b1;
                        response_data_out  <= response_next;
                    end else if (response_ready_in) begin
                        response_valid_out <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lutram_request_ctrl.sv
// tb_lutram_request_ctrl
//   Self-checking bench for lutram_request_ctrl. A behavioural single-port
//   LUTRAM (byte-masked synchronous write, combinational read) sits behind the
//   DUT. A transaction-level reference model (shadow memory plus expected
//   response register) predicts ready, response and init_done each cycle.
//   Build with +define+LUTRAM_REQUEST_CTRL_WRITE_ACK_EN to cover write acks.

module tb_lutram_request_ctrl;

    localparam int W  = 64;
    localparam int N  = 64;
    localparam int AW = 6;
    localparam int M  = 8;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic          request_valid_in = 1'b0;
    logic          request_ready_out;
    logic          request_write_in = 1'b0;
    logic [AW-1:0] request_addr_in = '0;
    logic [M-1:0]  request_mask_in = '0;
    logic [W-1:0]  request_data_in = '0;
    logic          response_valid_out;
    logic          response_ready_in = 1'b0;
    logic [W-1:0]  response_data_out;
    logic          init_done_out;
    logic          lutram_access_en_out;
    logic [M-1:0]  lutram_write_en_out;
    logic [AW-1:0] lutram_set_addr_out;
    logic [W-1:0]  lutram_write_entry_out;
    logic [W-1:0]  lutram_read_entry_in;

    always #5 clk_in = ~clk_in;

    lutram_request_ctrl #(
        .SINGLE_ENTRY_SIZE_IN_BITS(W),
        .NUM_SET(N)
    ) dut (
        .clk_in                (clk_in),
        .reset_in              (reset_in),
        .request_valid_in      (request_valid_in),
        .request_ready_out     (request_ready_out),
        .request_write_in      (request_write_in),
        .request_addr_in       (request_addr_in),
        .request_mask_in       (request_mask_in),
        .request_data_in       (request_data_in),
        .response_valid_out    (response_valid_out),
        .response_ready_in     (response_ready_in),
        .response_data_out     (response_data_out),
        .init_done_out         (init_done_out),
        .lutram_access_en_out  (lutram_access_en_out),
        .lutram_write_en_out   (lutram_write_en_out),
        .lutram_set_addr_out   (lutram_set_addr_out),
        .lutram_write_entry_out(lutram_write_entry_out),
        .lutram_read_entry_in  (lutram_read_entry_in)
    );

    // Behavioural LUTRAM, seeded with random garbage so the sweep matters.
    logic [W-1:0] lutram_mem [N];
    logic         seeded = 1'b0;

    assign lutram_read_entry_in = lutram_mem[lutram_set_addr_out];

    always @(posedge clk_in) begin
        if (!seeded) begin
            for (int i = 0; i < N; i++) lutram_mem[i] <= {$urandom, $urandom};
            seeded <= 1'b1;
        end else if (lutram_access_en_out) begin
            for (int b = 0; b < M; b++)
                if (lutram_write_en_out[b])
                    lutram_mem[lutram_set_addr_out][b*8 +: 8] <= lutram_write_entry_out[b*8 +: 8];
        end
    end

    // Reference model state.
    logic [W-1:0] ref_mem [N];
    bit           m_valid;
    logic [W-1:0] m_data;
    bit           m_init_done;
    int           m_init_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Drive one cycle of inputs at the falling edge, sample the combinational
    // ready shortly after, advance the model, then return just after the
    // rising edge so registered outputs can be compared.
    task automatic step(input bit rst, input bit v, input bit wr, input int addr,
                        input logic [M-1:0] mask, input logic [W-1:0] data, input bit rr,
                        output bit exp_ready, output logic got_ready);
        logic [W-1:0] old_entry;
        logic [W-1:0] new_entry;
        bit           load;
        @(negedge clk_in);
        reset_in          = rst;
        request_valid_in  = v;
        request_write_in  = wr;
        request_addr_in   = AW'(addr);
        request_mask_in   = mask;
        request_data_in   = data;
        response_ready_in = rr;
        #1;
        got_ready = request_ready_out;
        exp_ready = 1'b0;
        if (rst) begin
            m_valid     = 1'b0;
            m_data      = '0;
            m_init_done = 1'b0;
            m_init_cnt  = 0;
        end else if (!m_init_done) begin
            ref_mem[m_init_cnt] = '0;
            m_init_cnt++;
            if (m_init_cnt == N) m_init_done = 1'b1;
        end else begin
            exp_ready = !m_valid || rr;
            if (v && exp_ready) begin
                old_entry = ref_mem[addr];
                new_entry = old_entry;
                if (wr)
                    for (int b = 0; b < M; b++)
                        if (mask[b]) new_entry[b*8 +: 8] = data[b*8 +: 8];
                ref_mem[addr] = new_entry;
                load = !wr;
`ifdef LUTRAM_REQUEST_CTRL_WRITE_ACK_EN
                load = 1'b1;
`endif
                if (load) begin
                    m_valid = 1'b1;
                    m_data  = wr ? new_entry : old_entry;
                end else if (rr) begin
                    m_valid = 1'b0;
                end
            end else if (rr) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        bit er; logic gr;
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 1, 7, 8'hFF, {$urandom, $urandom}, 1, er, gr);
            if (gr !== 1'b0) begin n_fail++; $display("FAIL reset ready: got %b expected 0", gr); end
            if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b expected 0", response_valid_out); end
            if (response_data_out !== '0) begin n_fail++; $display("FAIL reset data: got %h expected 0", response_data_out); end
            if (init_done_out !== 1'b0) begin n_fail++; $display("FAIL reset init_done: got %b expected 0", init_done_out); end
            n_checks += 4;
        end
        // Requests presented during the sweep must be refused; init_done
        // rises exactly N cycles after reset deasserts.
        for (int i = 0; i < N; i++) begin
            step(0, 1, $urandom_range(0, 1), $urandom_range(0, N-1), 8'hFF, {$urandom, $urandom}, 1, er, gr);
            if (gr !== 1'b0) begin n_fail++; $display("FAIL sweep ready cycle %0d: got %b expected 0", i, gr); end
            if (init_done_out !== (i == N-1)) begin n_fail++; $display("FAIL sweep init_done cycle %0d: got %b expected %b", i, init_done_out, i == N-1); end
            n_checks += 2;
        end
        foreach (ref_mem[i]) begin end
        for (int k = 0; k < 3; k++) begin
            int a;
            a = (k == 0) ? 0 : (k == 1) ? 31 : 63;
            step(0, 1, 0, a, '0, '0, 1, er, gr);
            if (gr !== 1'b1) begin n_fail++; $display("FAIL post-sweep ready set %0d: got %b expected 1", a, gr); end
            if (response_valid_out !== 1'b1) begin n_fail++; $display("FAIL post-sweep valid set %0d: got %b expected 1", a, response_valid_out); end
            if (response_data_out !== 64'h0) begin n_fail++; $display("FAIL post-sweep data set %0d: got %h expected 0", a, response_data_out); end
            n_checks += 3;
        end
    endtask

    task automatic test_write_read();
        bit er; logic gr;
        bit           wr_t   [6] = '{1, 0, 1, 0, 1, 0};
        logic [M-1:0] mask_t [6] = '{8'hFF, 8'h00, 8'h0F, 8'h00, 8'h00, 8'h00};
        logic [W-1:0] data_t [6] = '{64'h1122334455667788, 64'h0, 64'hAAAAAAAAAAAAAAAA, 64'h0, 64'hDEADBEEFDEADBEEF, 64'h0};
        logic [W-1:0] exp_t  [6] = '{64'h0, 64'h1122334455667788, 64'h0, 64'h11223344AAAAAAAA, 64'h0, 64'h11223344AAAAAAAA};
        for (int i = 0; i < 6; i++) begin
            step(0, 1, wr_t[i], 5, mask_t[i], data_t[i], 1, er, gr);
            if (gr !== er) begin n_fail++; $display("FAIL wr/rd ready step %0d: got %b expected %b", i, gr, er); end
            if (response_valid_out !== m_valid) begin n_fail++; $display("FAIL wr/rd valid step %0d: got %b expected %b", i, response_valid_out, m_valid); end
            n_checks += 2;
            if (!wr_t[i]) begin
                if (response_data_out !== exp_t[i]) begin n_fail++; $display("FAIL wr/rd data step %0d: got %h expected %h", i, response_data_out, exp_t[i]); end
                n_checks++;
            end
        end
    endtask

    task automatic test_backpressure();
        bit er; logic gr;
        logic [W-1:0] held;
        step(0, 0, 0, 0, '0, '0, 1, er, gr);
        step(0, 1, 0, 5, '0, '0, 0, er, gr);
        held = m_data;
        if (response_valid_out !== 1'b1 || response_data_out !== 64'h11223344AAAAAAAA) begin
            n_fail++; $display("FAIL bp first read: got %b/%h expected 1/11223344aaaaaaaa", response_valid_out, response_data_out);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, '0, '0, 0, er, gr);
            if (gr !== 1'b0) begin n_fail++; $display("FAIL bp ready stall %0d: got %b expected 0", i, gr); end
            if (response_valid_out !== 1'b1) begin n_fail++; $display("FAIL bp valid stall %0d: got %b expected 1", i, response_valid_out); end
            if (response_data_out !== held) begin n_fail++; $display("FAIL bp data stall %0d: got %h expected %h", i, response_data_out, held); end
            n_checks += 3;
        end
        step(0, 1, 0, 0, '0, '0, 1, er, gr);
        if (gr !== 1'b1) begin n_fail++; $display("FAIL bp release ready: got %b expected 1", gr); end
        if (response_valid_out !== 1'b1) begin n_fail++; $display("FAIL bp release valid: got %b expected 1", response_valid_out); end
        if (response_data_out !== ref_mem[0]) begin n_fail++; $display("FAIL bp release data: got %h expected %h", response_data_out, ref_mem[0]); end
        n_checks += 3;
        step(0, 0, 0, 0, '0, '0, 1, er, gr);
        if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL bp drain valid: got %b expected 0", response_valid_out); end
        n_checks++;
    endtask

    task automatic test_random();
        bit er; logic gr;
        for (int i = 0; i < 400; i++) begin
            step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, N-1),
                 M'($urandom), {$urandom, $urandom}, $urandom_range(0, 2) != 0, er, gr);
            if (gr !== er) begin n_fail++; $display("FAIL rand ready %0d: got %b expected %b", i, gr, er); end
            if (response_valid_out !== m_valid) begin n_fail++; $display("FAIL rand valid %0d: got %b expected %b", i, response_valid_out, m_valid); end
            if (response_data_out !== m_data) begin n_fail++; $display("FAIL rand data %0d: got %h expected %h", i, response_data_out, m_data); end
            if (init_done_out !== 1'b1) begin n_fail++; $display("FAIL rand init_done %0d: got %b expected 1", i, init_done_out); end
            n_checks += 4;
        end
    endtask

    task automatic test_reset_mid();
        bit er; logic gr;
        step(0, 1, 1, 5, 8'hFF, 64'h0123456789ABCDEF, 1, er, gr);
        step(0, 1, 0, 5, '0, '0, 0, er, gr);
        step(1, 1, 0, 6, '0, '0, 0, er, gr);
        if (gr !== 1'b0) begin n_fail++; $display("FAIL midreset ready: got %b expected 0", gr); end
        if (response_valid_out !== 1'b0) begin n_fail++; $display("FAIL midreset valid: got %b expected 0", response_valid_out); end
        if (init_done_out !== 1'b0) begin n_fail++; $display("FAIL midreset init_done: got %b expected 0", init_done_out); end
        n_checks += 3;
        for (int i = 0; i < N; i++) begin
            step(0, 1, 0, 5, '0, '0, 1, er, gr);
            if (gr !== 1'b0) begin n_fail++; $display("FAIL midreset sweep ready %0d: got %b expected 0", i, gr); end
            n_checks++;
        end
        if (init_done_out !== 1'b1) begin n_fail++; $display("FAIL midreset init_done after sweep: got %b expected 1", init_done_out); end
        step(0, 1, 0, 5, '0, '0, 1, er, gr);
        if (response_valid_out !== 1'b1 || response_data_out !== 64'h0) begin
            n_fail++; $display("FAIL midreset read set 5: got %b/%h expected 1/0", response_valid_out, response_data_out);
        end
        n_checks += 2;
    endtask

`ifdef LUTRAM_REQUEST_CTRL_WRITE_ACK_EN
    task automatic test_write_ack();
        bit er; logic gr;
        step(0, 1, 1, 9, 8'hFF, 64'h0, 1, er, gr);
        if (response_valid_out !== 1'b1 || response_data_out !== 64'h0) begin
            n_fail++; $display("FAIL ack full write: got %b/%h expected 1/0", response_valid_out, response_data_out);
        end
        step(0, 1, 1, 9, 8'h01, 64'hFFFFFFFFFFFFFFFF, 1, er, gr);
        if (response_valid_out !== 1'b1 || response_data_out !== 64'h00000000000000FF) begin
            n_fail++; $display("FAIL ack masked write: got %b/%h expected 1/00000000000000ff", response_valid_out, response_data_out);
        end
        n_checks += 2;
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef LUTRAM_REQUEST_CTRL_WRITE_ACK_EN
        test_write_ack();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lutram_request_ctrl.md
Name: lutram_request_ctrl

Overview:
- Request front-end that sits directly upstream of single_port_lutram and drives all of its access ports.
- Accepts read and byte-masked write requests over a valid/ready handshake.
- Registers the LUTRAM's combinational read data into a one-entry response stage with its own valid/ready handshake.
- After every reset, sweeps all sets to zero before it accepts any request.

Parameters:
- SINGLE_ENTRY_SIZE_IN_BITS, 64: entry width; must be a multiple of `BYTE_LEN_IN_BITS.
- NUM_SET, 64: number of LUTRAM sets.
- SET_PTR_WIDTH_IN_BITS, $clog2(NUM_SET): set address width.
- WRITE_MASK_LEN, SINGLE_ENTRY_SIZE_IN_BITS / `BYTE_LEN_IN_BITS: one mask bit per byte lane.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- request_valid_in  input  1  upstream request present.
- request_ready_out  output  1  request accepted this cycle when valid and ready are both high.
- request_write_in  input  1  1 = write, 0 = read.
- request_addr_in  input  SET_PTR_WIDTH_IN_BITS  target set.
- request_mask_in  input  WRITE_MASK_LEN  byte-lane write mask; ignored for reads.
- request_data_in  input  SINGLE_ENTRY_SIZE_IN_BITS  write data.
- response_valid_out  output  1  response held.
- response_ready_in  input  1  downstream consumes the response.
- response_data_out  output  SINGLE_ENTRY_SIZE_IN_BITS  read data.
- init_done_out  output  1  zero sweep complete.
- lutram_access_en_out  output  1  to LUTRAM access_en_in.
- lutram_write_en_out  output  WRITE_MASK_LEN  to LUTRAM write_en_in.
- lutram_set_addr_out  output  SET_PTR_WIDTH_IN_BITS  to LUTRAM access_set_addr_in.
- lutram_write_entry_out  output  SINGLE_ENTRY_SIZE_IN_BITS  to LUTRAM write_entry_in.
- lutram_read_entry_in  input  SINGLE_ENTRY_SIZE_IN_BITS  from LUTRAM read_entry_out (combinational read).

Behaviour:
- Reset values: response_valid_out=0, response_data_out=0, init_done_out=0, init counter=0, state=INIT.
- States:
  - INIT -> IDLE when the counter reaches NUM_SET-1 and that set has been written.
  - IDLE is the only state besides INIT; no other transitions.
- INIT:
  - Each cycle: lutram_access_en_out=1, lutram_write_en_out=all ones, lutram_set_addr_out=counter, lutram_write_entry_out=0.
  - Counter increments by 1 each cycle, so the sweep takes exactly NUM_SET cycles.
  - The cycle after the last write: init_done_out=1 and the block is in IDLE.
  - request_ready_out=0 throughout INIT.
- IDLE:
  - request_ready_out = !response_valid_out || response_ready_in. This is combinational, so a back-to-back read accepted while the held response drains gives full throughput.
  - LUTRAM ports are driven combinationally from the request: access_en = valid&&ready; set_addr = request_addr_in; write_entry = request_data_in; write_en = request_mask_in when accepted write, else 0.
- Read accepted in cycle N:
  - lutram_read_entry_in is captured into response_data_out at the end of cycle N.
  - response_valid_out=1 from cycle N+1. Latency is 1 cycle.
- Write accepted in cycle N:
  - Lanes with mask bit 1 update at the end of cycle N; lanes with mask bit 0 are untouched.
  - No response is generated (unless the optional feature is compiled in).
  - A read of the same set in cycle N+1 returns the new data.
- Write with all-zero mask: accepted; no LUTRAM change.
- Response clears when response_valid_out && response_ready_in and no new read is accepted in the same cycle. If a new read is accepted in that cycle, response_data_out reloads and response_valid_out stays 1.
- response_data_out holds its value while valid and not ready.
- Address at the last set (NUM_SET-1): no special case; the init counter does not wrap.
- reset_in mid-operation:
  - An in-flight response is dropped and init restarts at set 0.
  - A request presented in the reset cycle is not accepted.

Optional Feature:
- Macro: LUTRAM_REQUEST_CTRL_WRITE_ACK_EN.
- Defined:
  - An accepted write also produces a response, with the same 1-cycle latency and backpressure as a read.
  - response_data_out = merged entry: per byte lane, request_data_in where the mask bit is 1, else the lutram_read_entry_in lane (pre-write contents).
- Undefined: writes produce no response (default).

Test Plan:
- Reset, observe sweep -> init_done_out rises exactly NUM_SET=64 cycles after reset deasserts; ready low until then. Reading sets 0, 31 and 63 afterwards returns 0x0.
- Write set 5, data 0x1122334455667788, mask 0xFF; read set 5 the next cycle -> response_valid_out the following cycle with 0x1122334455667788.
- Write set 5, data 0xAAAAAAAAAAAAAAAA, mask 0x0F; read set 5 -> 0x11223344AAAAAAAA.
- Read set 5 with response_ready_in held 0 for 3 cycles -> request_ready_out=0, response stable; release ready with a new read of set 0 presented -> both accepted back-to-back and valid stays 1.
- Assert reset_in while a response is pending -> response_valid_out=0 the next cycle, init restarts, and set 5 reads 0x0 after the sweep.
- With LUTRAM_REQUEST_CTRL_WRITE_ACK_EN: write set 9, data 0xFFFFFFFFFFFFFFFF, mask 0x01 after a full write of 0x0 -> response 0x00000000000000FF.
